conv_controller: RTL and testbench

- Sequencing FSM for the multi-filter convolution datapath.
- Generates every enable, select and counter value the datapath consumes: filter-buffer fill, image-buffer fill, slice extraction, PE MAC accumulation, result packing and result write-back.
- Sits between the top-level start/done handshake and the datapath; one instance per datapath.

---
 rtl/conv_controller_pkg.sv | 41 ++++
 rtl/conv_controller_if.sv | 45 ++++
 rtl/conv_controller_mod_counter.sv | 26 ++
 rtl/conv_controller.sv | 214 +++++++++++++++++++++
 tb/tb_conv_controller.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_controller_pkg.sv
// rtl/conv_controller_pkg.sv - shared states, select encodings and control bundle for conv_controller
package conv_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_F,
    LOAD_I,
    SLICE,
    MAC,
    STORE,
    WRITE,
    NEXT_B,
    DONE
  } state_t;

  localparam logic [1:0] OFFSET_Y = 2'd0;
  localparam logic [1:0] OFFSET_X = 2'd1;
  localparam logic [1:0] OFFSET_Z = 2'd2;

  localparam logic ADR_FILTER = 1'b0;
  localparam logic ADR_IMG    = 1'b1;

  // Per-cycle control outputs decoded from the current state
  typedef struct packed {
    logic       busy;
    logic       done;
    logic       mem_en;
    logic       filter_wr_en;
    logic       img_wr_en;
    logic       img_slice_en;
    logic       acc_en;
    logic       rst_acc;
    logic       res_buffer_en;
    logic       rst_res_reg;
    logic       inc_en;
    logic       inc_ld;
    logic       adr_sel;
    logic [1:0] mem_offset_sel;
  } ctrl_t;

endpackage

// File: rtl/conv_controller_if.sv
// rtl/conv_controller_if.sv - start/done handshake and datapath control bundle
interface conv_controller_if;

  logic       start;
  logic       busy;
  logic       done;
  logic       mem_en;
  logic       wr_file;
  logic       filter_wr_en;
  logic       img_wr_en;
  logic       img_slice_en;
  logic       acc_en;
  logic       rst_acc;
  logic       res_buffer_en;
  logic       rst_res_reg;
  logic       inc_en;
  logic       inc_ld;
  logic       adr_sel;
  logic [1:0] mem_offset_sel;
  logic [7:0] countr16_img;
  logic [7:0] countr4_filter;
  logic [7:0] countr_filters;
  logic [7:0] countr43;
  logic [7:0] row_countr;
  logic [7:0] col_countr;
  logic [7:0] countr16;
  logic [7:0] countr_reg4;

  modport master (
    input  start,
    output busy, done, mem_en, wr_file, filter_wr_en, img_wr_en, img_slice_en,
           acc_en, rst_acc, res_buffer_en, rst_res_reg, inc_en, inc_ld, adr_sel,
           mem_offset_sel, countr16_img, countr4_filter, countr_filters, countr43,
           row_countr, col_countr, countr16, countr_reg4
  );

  modport slave (
    output start,
    input  busy, done, mem_en, wr_file, filter_wr_en, img_wr_en, img_slice_en,
           acc_en, rst_acc, res_buffer_en, rst_res_reg, inc_en, inc_ld, adr_sel,
           mem_offset_sel, countr16_img, countr4_filter, countr_filters, countr43,
           row_countr, col_countr, countr16, countr_reg4
  );

endinterface

// File: rtl/conv_controller_mod_counter.sv
// rtl/conv_controller_mod_counter.sv - 8-bit wrapping counter with clear and terminal count
module mod_counter #(
  parameter int MAX = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [7:0] count,
  output logic       tc
);

  assign tc = (count == 8'(MAX));

  // Clear wins over step; a step from MAX wraps back to zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? 8'd0 : count + 8'd1;
    end
  end

endmodule

// File: rtl/conv_controller.sv
// rtl/conv_controller.sv - convolution datapath sequencer; optional CONV_CTRL_PAUSE_EN adds a pause input
module conv_controller
  import conv_ctrl_pkg::*;
#(
  parameter int NUM_FILTERS = 4,
  parameter int IMG_WORDS   = 16,
  parameter int SLICE_ROWS  = 4,
  parameter int MAC_STEPS   = 16,
  parameter int NUM_COLS    = 12,
  parameter int NUM_BANDS   = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef CONV_CTRL_PAUSE_EN
  input  logic pause,
`endif
  conv_controller_if.master bus
);

  state_t state;
  state_t state_next;
  ctrl_t  ctl;
  logic   hold;

  logic start_go;
  logic en_f4, en_ff, en_img, en_row, en_c16, en_col, en_r4, en_c43, en_band;
  logic clr_band_ctx, clr_r4;

  logic [7:0] c_f4, c_ff, c_img, c_row, c_c16, c_col, c_r4, c_c43;
  logic [7:0] band_cnt_unused;
  logic       tc_f4, tc_ff, tc_img, tc_row, tc_c16, tc_col, tc_r4, tc_band;
  logic       c43_wrap_unused;

`ifdef CONV_CTRL_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // State register; reset aborts any run straight back to IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state, Moore controls and counter step/clear requests
  always_comb begin
    state_next   = state;
    ctl          = '0;
    ctl.adr_sel  = ADR_FILTER;
    ctl.mem_offset_sel = OFFSET_Y;
    start_go     = 1'b0;
    en_f4        = 1'b0;
    en_ff        = 1'b0;
    en_img       = 1'b0;
    en_row       = 1'b0;
    en_c16       = 1'b0;
    en_col       = 1'b0;
    en_r4        = 1'b0;
    en_c43       = 1'b0;
    en_band      = 1'b0;
    clr_band_ctx = 1'b0;
    clr_r4       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          start_go        = 1'b1;
          ctl.inc_ld      = 1'b1;
          ctl.rst_res_reg = 1'b1;
          state_next      = LOAD_F;
        end
      end
      LOAD_F: begin
        ctl.busy           = 1'b1;
        ctl.filter_wr_en   = 1'b1;
        ctl.adr_sel        = ADR_FILTER;
        ctl.mem_offset_sel = OFFSET_Z;
        en_f4              = 1'b1;
        en_ff              = tc_f4;
        if (tc_f4 && tc_ff) state_next = LOAD_I;
      end
      LOAD_I: begin
        ctl.busy           = 1'b1;
        ctl.img_wr_en      = 1'b1;
        ctl.adr_sel        = ADR_IMG;
        ctl.mem_offset_sel = OFFSET_X;
        en_img             = 1'b1;
        if (tc_img) state_next = SLICE;
      end
      SLICE: begin
        ctl.busy         = 1'b1;
        ctl.img_slice_en = 1'b1;
        en_row           = 1'b1;
        if (tc_row) state_next = MAC;
      end
      MAC: begin
        ctl.busy    = 1'b1;
        ctl.acc_en  = 1'b1;
        ctl.rst_acc = (c_c16 == 8'd0);
        en_c16      = 1'b1;
        if (tc_c16) state_next = STORE;
      end
      STORE: begin
        ctl.busy          = 1'b1;
        ctl.res_buffer_en = 1'b1;
        en_r4             = 1'b1;
        // A full group of four or the last column forces a write-back
        if (tc_r4 || tc_col) begin
          state_next = WRITE;
        end else begin
          en_col     = 1'b1;
          state_next = SLICE;
        end
      end
      WRITE: begin
        ctl.busy           = 1'b1;
        ctl.mem_en         = 1'b1;
        ctl.mem_offset_sel = OFFSET_Y;
        en_c43             = 1'b1;
        clr_r4             = 1'b1;
        if (!tc_col) begin
          en_col     = 1'b1;
          state_next = SLICE;
        end else if (!tc_band) begin
          state_next = NEXT_B;
        end else begin
          state_next = DONE;
        end
      end
      NEXT_B: begin
        ctl.busy     = 1'b1;
        ctl.inc_en   = 1'b1;
        clr_band_ctx = 1'b1;
        en_band      = 1'b1;
        state_next   = LOAD_I;
      end
      DONE: begin
        ctl.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Pause freezes everything and silences strobes; selects follow the held state
    if (hold) begin
      state_next        = state;
      start_go          = 1'b0;
      en_f4             = 1'b0;
      en_ff             = 1'b0;
      en_img            = 1'b0;
      en_row            = 1'b0;
      en_c16            = 1'b0;
      en_col            = 1'b0;
      en_r4             = 1'b0;
      en_c43            = 1'b0;
      en_band           = 1'b0;
      clr_band_ctx      = 1'b0;
      clr_r4            = 1'b0;
      ctl.mem_en        = 1'b0;
      ctl.filter_wr_en  = 1'b0;
      ctl.img_wr_en     = 1'b0;
      ctl.img_slice_en  = 1'b0;
      ctl.acc_en        = 1'b0;
      ctl.rst_acc       = 1'b0;
      ctl.res_buffer_en = 1'b0;
      ctl.rst_res_reg   = 1'b0;
      ctl.inc_en        = 1'b0;
      ctl.inc_ld        = 1'b0;
    end
  end

  mod_counter #(.MAX(3)) u_f4 (
    .clk(clk), .rst(rst), .en(en_f4), .clr(start_go), .count(c_f4), .tc(tc_f4));
  mod_counter #(.MAX(NUM_FILTERS - 1)) u_ff (
    .clk(clk), .rst(rst), .en(en_ff), .clr(start_go), .count(c_ff), .tc(tc_ff));
  mod_counter #(.MAX(IMG_WORDS - 1)) u_img (
    .clk(clk), .rst(rst), .en(en_img), .clr(start_go | clr_band_ctx), .count(c_img), .tc(tc_img));
  mod_counter #(.MAX(SLICE_ROWS - 1)) u_row (
    .clk(clk), .rst(rst), .en(en_row), .clr(start_go | clr_band_ctx), .count(c_row), .tc(tc_row));
  mod_counter #(.MAX(MAC_STEPS - 1)) u_c16 (
    .clk(clk), .rst(rst), .en(en_c16), .clr(start_go), .count(c_c16), .tc(tc_c16));
  mod_counter #(.MAX(NUM_COLS - 1)) u_col (
    .clk(clk), .rst(rst), .en(en_col), .clr(start_go | clr_band_ctx), .count(c_col), .tc(tc_col));
  mod_counter #(.MAX(3)) u_r4 (
    .clk(clk), .rst(rst), .en(en_r4), .clr(start_go | clr_r4), .count(c_r4), .tc(tc_r4));
  mod_counter #(.MAX(255)) u_c43 (
    .clk(clk), .rst(rst), .en(en_c43), .clr(start_go), .count(c_c43), .tc(c43_wrap_unused));
  mod_counter #(.MAX(NUM_BANDS - 1)) u_band (
    .clk(clk), .rst(rst), .en(en_band), .clr(start_go), .count(band_cnt_unused), .tc(tc_band));

  assign bus.busy           = ctl.busy;
  assign bus.done           = ctl.done;
  assign bus.mem_en         = ctl.mem_en;
  assign bus.wr_file        = ctl.mem_en;
  assign bus.filter_wr_en   = ctl.filter_wr_en;
  assign bus.img_wr_en      = ctl.img_wr_en;
  assign bus.img_slice_en   = ctl.img_slice_en;
  assign bus.acc_en         = ctl.acc_en;
  assign bus.rst_acc        = ctl.rst_acc;
  assign bus.res_buffer_en  = ctl.res_buffer_en;
  assign bus.rst_res_reg    = ctl.rst_res_reg;
  assign bus.inc_en         = ctl.inc_en;
  assign bus.inc_ld         = ctl.inc_ld;
  assign bus.adr_sel        = ctl.adr_sel;
  assign bus.mem_offset_sel = ctl.mem_offset_sel;
  assign bus.countr4_filter = c_f4;
  assign bus.countr_filters = c_ff;
  assign bus.countr16_img   = c_img;
  assign bus.row_countr     = c_row;
  assign bus.countr16       = c_c16;
  assign bus.col_countr     = c_col;
  assign bus.countr_reg4    = c_r4;
  assign bus.countr43       = c_c43;

endmodule

// File: tb/tb_conv_controller.sv
// tb/tb_conv_controller.sv - randomized trace check of conv_controller against a loop-nest model
module tb_conv_controller;

  localparam int NF = 4, IMG = 16, ROWS = 4, MACS = 16, NB = 4;
  localparam int K_LF = 0, K_LI = 1, K_SL = 2, K_MAC = 3, K_ST = 4, K_WR = 5, K_NB = 6, K_DN = 7, K_ID = 8;

  typedef struct packed {
    logic       busy, done, inc_ld, rst_res_reg, filter_wr_en, img_wr_en, img_slice_en;
    logic       acc_en, rst_acc, res_buffer_en, mem_en, wr_file, inc_en, adr_sel;
    logic [1:0] mem_offset_sel;
    logic [7:0] countr4_filter, countr_filters, countr16_img, row_countr;
    logic [7:0] countr16, col_countr, countr_reg4, countr43;
  } obs_t;

  typedef struct packed {
    obs_t v;
    obs_t m;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  conv_controller_if ifa ();
  conv_controller_if ifb ();

  conv_controller dut_a (
    .clk(clk), .rst(rst),
`ifdef CONV_CTRL_PAUSE_EN
    .pause(1'b0),
`endif
    .bus(ifa));

  conv_controller #(.NUM_COLS(10)) dut_b (
    .clk(clk), .rst(rst),
`ifdef CONV_CTRL_PAUSE_EN
    .pause(1'b0),
`endif
    .bus(ifb));

  always #5 clk = ~clk;

  obs_t obs_a, obs_b;
  assign obs_a = {ifa.busy, ifa.done, ifa.inc_ld, ifa.rst_res_reg, ifa.filter_wr_en, ifa.img_wr_en,
                  ifa.img_slice_en, ifa.acc_en, ifa.rst_acc, ifa.res_buffer_en, ifa.mem_en, ifa.wr_file,
                  ifa.inc_en, ifa.adr_sel, ifa.mem_offset_sel, ifa.countr4_filter, ifa.countr_filters,
                  ifa.countr16_img, ifa.row_countr, ifa.countr16, ifa.col_countr, ifa.countr_reg4, ifa.countr43};
  assign obs_b = {ifb.busy, ifb.done, ifb.inc_ld, ifb.rst_res_reg, ifb.filter_wr_en, ifb.img_wr_en,
                  ifb.img_slice_en, ifb.acc_en, ifb.rst_acc, ifb.res_buffer_en, ifb.mem_en, ifb.wr_file,
                  ifb.inc_en, ifb.adr_sel, ifb.mem_offset_sel, ifb.countr4_filter, ifb.countr_filters,
                  ifb.countr16_img, ifb.row_countr, ifb.countr16, ifb.col_countr, ifb.countr_reg4, ifb.countr43};

  exp_t mq[$];
  exp_t qa[$];
  exp_t qb[$];
  int m_f4, m_ff, m_img, m_row, m_c16, m_col, m_r4, m_c43;
  int n_busy_a, n_busy_b, n_wr_a, n_wr_b, n_inc_a, n_done_a, n_done_b, n_fw_a;

  // One expected cycle: what that phase asserts plus the counters visible during it
  function automatic void emit(input int k, input bit first);
    exp_t e;
    e.v = '0;
    e.m = '0;
    {e.m.busy, e.m.done, e.m.inc_ld, e.m.rst_res_reg, e.m.filter_wr_en, e.m.img_wr_en, e.m.img_slice_en,
     e.m.acc_en, e.m.rst_acc, e.m.res_buffer_en, e.m.mem_en, e.m.wr_file, e.m.inc_en} = '1;
    e.m.col_countr  = '1;
    e.m.countr_reg4 = '1;
    e.m.countr43    = '1;
    e.v.col_countr  = 8'(m_col);
    e.v.countr_reg4 = 8'(m_r4);
    e.v.countr43    = 8'(m_c43);
    e.v.busy        = (k != K_DN) && (k != K_ID);
    case (k)
      K_LF: begin
        e.v.filter_wr_en = 1'b1;
        e.v.mem_offset_sel = 2'd2;
        e.m.adr_sel = 1'b1; e.m.mem_offset_sel = '1;
        e.m.countr4_filter = '1; e.m.countr_filters = '1;
        e.v.countr4_filter = 8'(m_f4); e.v.countr_filters = 8'(m_ff);
      end
      K_LI: begin
        e.v.img_wr_en = 1'b1;
        e.v.adr_sel = 1'b1; e.v.mem_offset_sel = 2'd1;
        e.m.adr_sel = 1'b1; e.m.mem_offset_sel = '1;
        e.m.countr16_img = '1; e.v.countr16_img = 8'(m_img);
      end
      K_SL: begin
        e.v.img_slice_en = 1'b1;
        e.m.row_countr = '1; e.v.row_countr = 8'(m_row);
      end
      K_MAC: begin
        e.v.acc_en = 1'b1;
        e.v.rst_acc = first;
        e.m.countr16 = '1; e.v.countr16 = 8'(m_c16);
      end
      K_ST: e.v.res_buffer_en = 1'b1;
      K_WR: begin
        e.v.mem_en = 1'b1; e.v.wr_file = 1'b1;
        e.m.mem_offset_sel = '1;
        e.m.countr_reg4 = '0;
      end
      K_NB: e.v.inc_en = 1'b1;
      K_DN: e.v.done = 1'b1;
      default: ;
    endcase
    mq.push_back(e);
  endfunction

  // Whole run as nested loops: filters, then per band an image fill and per column slice/MAC/store
  function automatic void build(input int nc, input int pad);
    mq.delete();
    m_f4 = 0; m_ff = 0; m_img = 0; m_row = 0; m_c16 = 0; m_col = 0; m_r4 = 0; m_c43 = 0;
    for (int k = 0; k < 4 * NF; k++) begin
      m_f4 = k % 4; m_ff = k / 4;
      emit(K_LF, 1'b0);
    end
    for (int b = 0; b < NB; b++) begin
      for (int i = 0; i < IMG; i++) begin
        m_img = i;
        emit(K_LI, 1'b0);
      end
      for (int c = 0; c < nc; c++) begin
        bit flush;
        m_col = c;
        for (int r = 0; r < ROWS; r++) begin m_row = r; emit(K_SL, 1'b0); end
        for (int s = 0; s < MACS; s++) begin m_c16 = s; emit(K_MAC, s == 0); end
        emit(K_ST, 1'b0);
        flush = (m_r4 == 3) || (c == nc - 1);
        m_r4++;
        if (flush) begin
          emit(K_WR, 1'b0);
          m_c43++;
          m_r4 = 0;
        end
      end
      if (b < NB - 1) begin
        emit(K_NB, 1'b0);
        m_col = 0;
      end
    end
    emit(K_DN, 1'b0);
    while (mq.size() < pad) emit(K_ID, 1'b0);
  endfunction

  task automatic run_trace(input bit held, input bit use_b);
    n_busy_a = 0; n_busy_b = 0; n_wr_a = 0; n_wr_b = 0;
    n_inc_a = 0; n_done_a = 0; n_done_b = 0; n_fw_a = 0;
    @(posedge clk); #1;
    ifa.start = 1'b1;
    ifb.start = use_b;
    @(negedge clk);
    total++;
    if (!(ifa.inc_ld === 1'b1 && ifa.rst_res_reg === 1'b1 && ifa.busy === 1'b0)) begin
      bad++;
      $display("FAIL launch_a got inc_ld=%b rst_res_reg=%b busy=%b want 1 1 0", ifa.inc_ld, ifa.rst_res_reg, ifa.busy);
    end
    if (use_b) begin
      total++;
      if (!(ifb.inc_ld === 1'b1 && ifb.rst_res_reg === 1'b1 && ifb.busy === 1'b0)) begin
        bad++;
        $display("FAIL launch_b got inc_ld=%b rst_res_reg=%b busy=%b want 1 1 0", ifb.inc_ld, ifb.rst_res_reg, ifb.busy);
      end
    end
    for (int i = 0; i < qa.size(); i++) begin
      @(posedge clk); #1;
      ifa.start = held ? 1'b1 : 1'($urandom_range(0, 1));
      ifb.start = (use_b && i < qb.size() && qb[i].v.busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      total++;
      if ((obs_a & qa[i].m) !== (qa[i].v & qa[i].m)) begin
        bad++;
        $display("FAIL trace_a cycle %0d got %h want %h", i, obs_a & qa[i].m, qa[i].v & qa[i].m);
      end
      if (use_b) begin
        total++;
        if ((obs_b & qb[i].m) !== (qb[i].v & qb[i].m)) begin
          bad++;
          $display("FAIL trace_b cycle %0d got %h want %h", i, obs_b & qb[i].m, qb[i].v & qb[i].m);
        end
      end
      n_busy_a += int'(ifa.busy); n_busy_b += int'(ifb.busy);
      n_wr_a += int'(ifa.mem_en); n_wr_b += int'(ifb.mem_en);
      n_inc_a += int'(ifa.inc_en); n_fw_a += int'(ifa.filter_wr_en);
      n_done_a += int'(ifa.done); n_done_b += int'(ifb.done);
    end
    @(posedge clk); #1;
    ifa.start = held;
    ifb.start = 1'b0;
    @(negedge clk);
    total++;
    if (!(ifa.busy === 1'b0 && ifa.done === 1'b0 && ifa.inc_ld === held && ifa.countr43 === 8'd12)) begin
      bad++;
      $display("FAIL post_run_a got busy=%b done=%b inc_ld=%b countr43=%0d want 0 0 %b 12",
               ifa.busy, ifa.done, ifa.inc_ld, ifa.countr43, held);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (obs_a !== '0) begin bad++; $display("FAIL reset_a got %h want 0", obs_a); end
    total++;
    if (obs_b !== '0) begin bad++; $display("FAIL reset_b got %h want 0", obs_b); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (obs_a !== '0) begin bad++; $display("FAIL idle_a got %h want 0", obs_a); end
    total++;
    if (obs_b !== '0) begin bad++; $display("FAIL idle_b got %h want 0", obs_b); end
  endtask

  task automatic test_random_run();
    repeat ($urandom_range(0, 7)) @(negedge clk);
    run_trace(1'b0, 1'b1);
    total++;
    if (n_busy_a !== 1103) begin bad++; $display("FAIL busy_len_a got %0d want 1103", n_busy_a); end
    total++;
    if (n_busy_b !== 16 + 4 * (16 + 10 * 21 + 3) + 3) begin
      bad++; $display("FAIL busy_len_b got %0d want %0d", n_busy_b, 16 + 4 * (16 + 10 * 21 + 3) + 3);
    end
    total++;
    if (n_wr_a !== 12 || n_wr_b !== 12) begin
      bad++; $display("FAIL writes got a=%0d b=%0d want 12 12", n_wr_a, n_wr_b);
    end
    total++;
    if (n_inc_a !== 3) begin bad++; $display("FAIL inc_en_pulses got %0d want 3", n_inc_a); end
    total++;
    if (n_fw_a !== 4 * NF) begin bad++; $display("FAIL filter_fill got %0d want %0d", n_fw_a, 4 * NF); end
    total++;
    if (n_done_a !== 1 || n_done_b !== 1) begin
      bad++; $display("FAIL done_pulses got a=%0d b=%0d want 1 1", n_done_a, n_done_b);
    end
  endtask

  task automatic test_abort_mid_mac();
    int dn;
    @(posedge clk); #1;
    ifa.start = 1'b1;
    for (int i = 0; i <= 40; i++) begin
      @(posedge clk); #1;
      ifa.start = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if ((obs_a & qa[i].m) !== (qa[i].v & qa[i].m)) begin
        bad++;
        $display("FAIL abort_pre cycle %0d got %h want %h", i, obs_a & qa[i].m, qa[i].v & qa[i].m);
      end
    end
    total++;
    if (ifa.acc_en !== 1'b1) begin bad++; $display("FAIL abort_in_mac got acc_en=%b want 1", ifa.acc_en); end
    ifa.start = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if (obs_a !== '0) begin bad++; $display("FAIL abort_outputs got %h want 0", obs_a); end
    dn = 0;
    repeat (3) begin @(negedge clk); dn += int'(ifa.done); end
    rst = 1'b1;
    repeat (2) begin @(negedge clk); dn += int'(ifa.done); end
    total++;
    if (dn !== 0) begin bad++; $display("FAIL abort_no_done got %0d want 0", dn); end
    run_trace(1'b0, 1'b1);
    total++;
    if (n_busy_a !== 1103) begin bad++; $display("FAIL abort_rerun_busy got %0d want 1103", n_busy_a); end
  endtask

  task automatic test_start_held();
    run_trace(1'b1, 1'b0);
    total++;
    if (n_done_a !== 1) begin bad++; $display("FAIL held_done_pulses got %0d want 1", n_done_a); end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (!(ifa.busy === 1'b1 && ifa.filter_wr_en === 1'b1 && ifa.countr43 === 8'd0)) begin
      bad++;
      $display("FAIL held_relaunch got busy=%b filter_wr_en=%b countr43=%0d want 1 1 0",
               ifa.busy, ifa.filter_wr_en, ifa.countr43);
    end
    ifa.start = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    build(12, 0);
    qa = mq;
    build(10, qa.size());
    qb = mq;
    test_reset();
    test_random_run();
    test_random_run();
    test_abort_mid_mac();
    test_start_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
